// File: rtl/mult_iter_32_if.sv
// rtl/mult_iter_32_if.sv - start/busy/done handshake and operand/result bus for mult_iter_32
//
// Purpose: groups the multiply request and result signals between the
// pipeline (master) and the iterative multiplier (slave).
// Signals:
//   start      master->slave  request a multiply
//   is_signed  master->slave  1 = mult, 0 = multu
//   a, b       master->slave  32-bit multiplicand / multiplier
//   busy       slave->master  operation in progress
//   done       slave->master  one-cycle pulse, hi/lo just became valid
//   hi, lo     slave->master  product bits [63:32] / [31:0]
interface mult_iter_32_if;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_iter_32.sv
// rtl/mult_iter_32.sv - iterative 32x32->64 shift-add multiplier writing HI/LO
//
// Purpose: MIPS mult/multu unit. One partial-product accumulation per cycle
// through the fa_32 carry-select adder; fixed 34-cycle start-to-done latency
// (1 accept cycle, 32 RUN cycles, 1 FIX cycle).
// Optional feature macro: MULT_SIGNED_EN
//   defined   - is_signed honoured: magnitudes taken at start, product
//               negated in FIX when the operand signs differ.
//   undefined - every operation is unsigned; FIX copies the accumulator.
// Modules:
//   fa_32         32-bit carry-select adder (x + y + cin -> sum, cout)
//   mult_iter_32  ports: clk, rst_n (async active-low), bus (mult_iter_32_if.slave)

module fa_32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [16:0] lo_sum;
  logic [16:0] hi_sum0;
  logic [16:0] hi_sum1;

  // Low half ripples; high half is precomputed for both possible carries
  // and selected by the low-half carry-out.
  assign lo_sum  = {1'b0, x[15:0]} + {1'b0, y[15:0]} + {16'd0, cin};
  assign hi_sum0 = {1'b0, x[31:16]} + {1'b0, y[31:16]};
  assign hi_sum1 = {1'b0, x[31:16]} + {1'b0, y[31:16]} + 17'd1;

  assign sum[15:0]  = lo_sum[15:0];
  assign sum[31:16] = lo_sum[16] ? hi_sum1[15:0] : hi_sum0[15:0];
  assign cout       = lo_sum[16] ? hi_sum1[16]   : hi_sum0[16];
endmodule

module mult_iter_32 (
  input  logic            clk,
  input  logic            rst_n,
  mult_iter_32_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  count;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] addend;
  logic [31:0] fa_sum;
  logic        fa_cout;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [63:0] fix_prod;

  assign addend = mplier[0] ? mcand : 32'd0;

  fa_32 u_fa (
    .x    (acc_hi),
    .y    (addend),
    .cin  (1'b0),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

`ifdef MULT_SIGNED_EN
  logic neg;
  logic neg_in;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign a_in     = (bus.is_signed && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
  assign b_in     = (bus.is_signed && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
  assign neg_in   = bus.is_signed & (bus.a[31] ^ bus.b[31]);
  assign fix_prod = neg ? (~{acc_hi, acc_lo} + 64'd1) : {acc_hi, acc_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      neg <= neg_in;
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = bus.is_signed;
  assign a_in             = bus.a;
  assign b_in             = bus.b;
  assign fix_prod         = {acc_hi, acc_lo};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= 5'd0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= a_in;
            mplier <= b_in;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            count  <= 5'd0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // {cout, sum, acc_lo} >> 1: the bit falling out of sum enters the
          // low accumulator word from the top.
          acc_hi <= {fa_cout, fa_sum[31:1]};
          acc_lo <= {fa_sum[0], acc_lo[31:1]};
          mplier <= {1'b0, mplier[31:1]};
          count  <= count + 5'd1;
          if (count == 5'd31) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi_q   <= fix_prod[63:32];
          lo_q   <= fix_prod[31:0];
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_iter_32.sv
// tb/tb_mult_iter_32.sv - scoreboard testbench for mult_iter_32
module tb_mult_iter_32;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [63:0] exp_q[$];

  mult_iter_32_if bus();

  mult_iter_32 u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected product whenever the DUT pulses done.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        check("busy_with_done", {63'd0, bus.busy}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          check("product", {bus.hi, bus.lo}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    bus.start     = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = sgn;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    @(negedge clk);
    drive_start(a, b, sgn);
  endtask

  // Counts cycles after the accepting edge until done; optionally pulses a
  // stray start at cycle inject_at.
  task automatic wait_done(input int inject_at, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) bc++;
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
      if (n == inject_at) begin
        drive_start(32'hDEAD_BEEF, 32'h0000_0003, 1'b0);
      end
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [63:0] exp);
    int lat;
    int bc;
    exp_q.push_back(exp);
    issue(a, b, sgn);
    wait_done(0, lat, bc);
    check({name, "_latency"}, 64'(lat), 64'd34);
    check({name, "_busy_cycles"}, 64'(bc), 64'd33);
  endtask

  initial begin
    int lat;
    int bc;
    int dcnt;
    logic [63:0] exp_sgn;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;

    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_hi", {32'd0, bus.hi}, 64'd0);
    check("reset_lo", {32'd0, bus.lo}, 64'd0);
    rst_n = 1'b1;

    run_op("u3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
    run_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
`ifdef MULT_SIGNED_EN
    exp_sgn = 64'hFFFF_FFFF_FFFF_FFFA;
`else
    exp_sgn = 64'h0000_0002_FFFF_FFFA;
`endif
    run_op("s_m2x3", 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, exp_sgn);
    run_op("s_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);

    // Stray start mid-op is ignored; next start in the done cycle is accepted.
    exp_q.push_back(64'h0000_0001_2345_6780);
    issue(32'h1234_5678, 32'h0000_0010, 1'b0);
    wait_done(10, lat, bc);
    check("ignore_latency", 64'(lat), 64'd34);
    exp_q.push_back(64'h0000_0000_0000_4E20);
    drive_start(32'd100, 32'd200, 1'b0);
    wait_done(0, lat, bc);
    check("b2b_latency", 64'(lat), 64'd34);
    check("b2b_busy_cycles", 64'(bc), 64'd33);

    // Reset mid-op.
    issue(32'd9, 32'd9, 1'b0);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_done", {63'd0, bus.done}, 64'd0);
    check("midrst_hi", {32'd0, bus.hi}, 64'd0);
    check("midrst_lo", {32'd0, bus.lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcnt++;
    end
    check("midrst_no_done", 64'(dcnt), 64'd0);
    run_op("u7x6", 32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A);

    repeat (2) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
